// File: rtl/square_acc.sv
`default_nettype none
// ============================================================================
//  Module      : square_acc
//  Description : Two-stage radix-4 Booth squarer/multiplier with a saturating
//                frame accumulator and a valid/ready handshake.
//  Revision    : 1.0
// ============================================================================
module square_acc #(
    parameter int WIDTH     = 16,
    parameter int ACCW      = 40,
    parameter int FRAME_LEN = 256
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic                 mode,
    input  logic                 acc_en,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 acc_valid,
    output logic [ACCW-1:0]      acc_out,
    output logic                 acc_ovf
);

    localparam int c_npp  = WIDTH / 2;
    localparam int c_pw   = 2 * WIDTH;
    localparam int c_cntw = $clog2(FRAME_LEN);

    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(FRAME_LEN - 1);
    localparam logic [c_cntw-1:0] c_cnt_one  = c_cntw'(1);
    localparam logic [ACCW-1:0]   c_acc_max  = {1'b0, {(ACCW-1){1'b1}}};
    localparam logic [ACCW-1:0]   c_acc_min  = {1'b1, {(ACCW-1){1'b0}}};

    // ------------------------------------------------------------------
    // Stage-1 combinational: Booth recoding of the multiplier
    // ------------------------------------------------------------------
    logic [c_pw-1:0]  w_mcand;
    logic [WIDTH-1:0] w_mplier;
    logic [c_pw-1:0]  w_pp [c_npp];
    logic             w_adv;

    assign w_mcand  = {{WIDTH{in_a[WIDTH-1]}}, in_a};
    assign w_mplier = mode ? in_b : in_a;

    generate
        for (genvar g = 0; g < c_npp; g++) begin : g_booth
            logic [2:0]      w_grp;
            logic [c_pw-1:0] w_mag;

            if (g == 0) begin : g_lsb
                assign w_grp = {w_mplier[1:0], 1'b0};
            end else begin : g_mid
                assign w_grp = w_mplier[2*g+1 -: 3];
            end

            always_comb begin
                case (w_grp)
                    3'b001, 3'b010, 3'b101, 3'b110: w_mag = w_mcand;
                    3'b011, 3'b100:                 w_mag = w_mcand << 1;
                    default:                        w_mag = '0;
                endcase
            end

            assign w_pp[g] = (w_grp[2] ? -w_mag : w_mag) << (2 * g);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Pipeline registers
    // ------------------------------------------------------------------
    logic                r_s1_valid;
    logic                r_s1_acc_en;
    logic [c_pw-1:0]     r_s1_pp [c_npp];
    logic                r_out_valid;
    logic [c_pw-1:0]     r_prod;
    logic                r_acc_valid;
    logic [ACCW-1:0]     r_acc_out;
    logic                r_acc_ovf;
    logic [ACCW-1:0]     r_acc;
    logic                r_ovf;
    logic [c_cntw-1:0]   r_cnt;

    // The partial products already encode operands and mode, so only they travel.
    assign w_adv    = !(r_out_valid && !out_ready);
    assign in_ready = w_adv;

    // ------------------------------------------------------------------
    // Stage-2 combinational: reduction and saturating accumulation
    // ------------------------------------------------------------------
    logic [c_pw-1:0]        w_sum;
    logic signed [ACCW-1:0] w_prod_ext;
    logic [ACCW:0]          w_add;
    logic [ACCW-1:0]        w_acc_nxt;
    logic                   w_ovf_nxt;
    logic                   w_frame_end;

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < c_npp; i++) begin
            w_sum = w_sum + r_s1_pp[i];
        end
    end

    assign w_prod_ext  = ACCW'($signed(w_sum));
    assign w_add       = {r_acc[ACCW-1], r_acc} + {w_prod_ext[ACCW-1], w_prod_ext};
    assign w_frame_end = (r_cnt == c_cnt_last);

    // Once a frame saturates it holds the rail until the next frame loads.
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (r_cnt == '0) begin
            w_acc_nxt = w_prod_ext;
            w_ovf_nxt = 1'b0;
        end else if (!r_ovf) begin
            if (w_add[ACCW] != w_add[ACCW-1]) begin
                w_acc_nxt = w_add[ACCW] ? c_acc_min : c_acc_max;
                w_ovf_nxt = 1'b1;
            end else begin
                w_acc_nxt = w_add[ACCW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_s1_valid  <= 1'b0;
            r_s1_acc_en <= 1'b0;
            r_s1_pp     <= '{default: '0};
            r_out_valid <= 1'b0;
            r_prod      <= '0;
            r_acc_valid <= 1'b0;
            r_acc_out   <= '0;
            r_acc_ovf   <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_cnt       <= '0;
        end else if (w_adv) begin
            r_s1_valid  <= in_valid;
            if (in_valid) begin
                r_s1_acc_en <= acc_en;
                r_s1_pp     <= w_pp;
            end
            r_out_valid <= r_s1_valid;
            r_acc_valid <= 1'b0;
            if (r_s1_valid) begin
                r_prod <= w_sum;
                if (r_s1_acc_en) begin
                    r_acc <= w_acc_nxt;
                    r_ovf <= w_ovf_nxt;
                    if (w_frame_end) begin
                        r_cnt       <= '0;
                        r_acc_out   <= w_acc_nxt;
                        r_acc_ovf   <= w_ovf_nxt;
                        r_acc_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign prod      = r_prod;
    assign acc_valid = r_acc_valid;
    assign acc_out   = r_acc_out;
    assign acc_ovf   = r_acc_ovf;

endmodule
`default_nettype wire

// File: tb/tb_square_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_square_acc
//  Description : Scoreboard bench for square_acc (WIDTH=16, ACCW=32, FRAME_LEN=4).
//  Revision    : 1.0
// ============================================================================
module tb_square_acc;

    localparam int WIDTH     = 16;
    localparam int ACCW      = 32;
    localparam int FRAME_LEN = 4;
    localparam longint ACC_MAX = (longint'(1) <<< (ACCW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (ACCW - 1));

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic               mode;
    logic               acc_en;
    logic               out_valid;
    logic               out_ready;
    logic [2*WIDTH-1:0] prod;
    logic               acc_valid;
    logic [ACCW-1:0]    acc_out;
    logic               acc_ovf;

    square_acc #(.WIDTH(WIDTH), .ACCW(ACCW), .FRAME_LEN(FRAME_LEN)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .mode(mode), .acc_en(acc_en),
        .out_valid(out_valid), .out_ready(out_ready),
        .prod(prod), .acc_valid(acc_valid), .acc_out(acc_out), .acc_ovf(acc_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint prod;
        bit     accv;
        longint acc;
        bit     ovf;
    } exp_t;

    exp_t   sb[$];
    int     n_checks = 0;
    int     n_pass   = 0;
    longint m_acc, m_last;
    bit     m_ovf, m_last_ovf;
    int     m_cnt;

    task automatic check(input string name, input bit ok, input longint act, input longint req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    task automatic model_reset();
        m_acc = 0; m_last = 0; m_ovf = 0; m_last_ovf = 0; m_cnt = 0;
        sb.delete();
    endtask

    // Frame model: expected acc_out/acc_ovf hold the last completed frame.
    task automatic model_push(input longint p, input bit en);
        exp_t   e;
        longint t;
        e.prod = p;
        e.accv = 1'b0;
        if (en) begin
            if (m_cnt == 0) begin
                m_acc = p; m_ovf = 1'b0;
            end else if (!m_ovf) begin
                t = m_acc + p;
                if (t > ACC_MAX) begin t = ACC_MAX; m_ovf = 1'b1; end
                else if (t < ACC_MIN) begin t = ACC_MIN; m_ovf = 1'b1; end
                m_acc = t;
            end
            if (m_cnt == FRAME_LEN - 1) begin
                m_cnt = 0; e.accv = 1'b1; m_last = m_acc; m_last_ovf = m_ovf;
            end else begin
                m_cnt++;
            end
        end
        e.acc = m_last;
        e.ovf = m_last_ovf;
        sb.push_back(e);
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 1'b0, longint'($signed(prod)), 0);
                end else begin
                    e = sb.pop_front();
                    check("prod", longint'($signed(prod)) == e.prod, longint'($signed(prod)), e.prod);
                    check("acc_valid", acc_valid == e.accv, longint'(acc_valid), longint'(e.accv));
                    check("acc_out", longint'($signed(acc_out)) == e.acc, longint'($signed(acc_out)), e.acc);
                    check("acc_ovf", acc_ovf == e.ovf, longint'(acc_ovf), longint'(e.ovf));
                end
            end
        end
    endtask

    task automatic send(input int a, input int b, input bit m, input bit en, input longint p);
        bit acc;
        int waited = 0;
        in_a = 16'(a); in_b = 16'(b); mode = m; acc_en = en; in_valid = 1'b1;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            waited++;
            if (waited > 50) begin
                check("accept_timeout", 1'b0, waited, 50);
                in_valid = 1'b0;
                return;
            end
        end
        model_push(p, en);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain", sb.size() == 0, sb.size(), 0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        mode = 1'b0; acc_en = 1'b0; out_ready = 1'b1;
        model_reset();
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid == 1'b0, longint'(out_valid), 0);
        check("rst_acc_valid", acc_valid == 1'b0, longint'(acc_valid), 0);
        check("rst_prod", prod == '0, longint'(prod), 0);
        check("rst_acc_out", acc_out == '0, longint'(acc_out), 0);
        check("rst_acc_ovf", acc_ovf == 1'b0, longint'(acc_ovf), 0);
        check("rst_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Most-negative square and two-edge latency
        send(-32768, 1234, 1'b0, 1'b0, 64'sd1073741824);
        idle();
        check("lat_not_early", out_valid == 1'b0, longint'(out_valid), 0);
        @(posedge clk);
        #1;
        check("lat_valid", out_valid == 1'b1, longint'(out_valid), 1);
        check("lat_prod", longint'($signed(prod)) == 64'sd1073741824, longint'($signed(prod)), 64'sd1073741824);
        drain();

        // Back-to-back multiplies, then a square ignoring in_b
        send(3, -5, 1'b1, 1'b0, -64'sd15);
        send(-32768, 32767, 1'b1, 1'b0, -64'sd1073709056);
        send(-7, 999, 1'b0, 1'b0, 64'sd49);
        idle();
        drain();

        // Frame of 1,2,3,4 squares with a non-accumulated 7 interleaved
        send(1, 77, 1'b0, 1'b1, 64'sd1);
        send(2, 77, 1'b0, 1'b1, 64'sd4);
        send(7, 77, 1'b0, 1'b0, 64'sd49);
        send(3, 77, 1'b0, 1'b1, 64'sd9);
        send(4, 77, 1'b0, 1'b1, 64'sd16);
        idle();
        drain();

        // Output stall with full pipeline
        out_ready = 1'b0;
        fork
            begin
                send(5, 0, 1'b0, 1'b0, 64'sd25);
                send(6, 0, 1'b0, 1'b0, 64'sd36);
                send(7, 0, 1'b0, 1'b0, 64'sd49);
                idle();
            end
            begin
                int k = 0;
                @(negedge clk);
                while (!out_valid && k < 20) begin
                    @(negedge clk);
                    k++;
                end
                check("stall_fill", out_valid == 1'b1, longint'(out_valid), 1);
                repeat (5) begin
                    check("stall_in_ready", in_ready == 1'b0, longint'(in_ready), 0);
                    check("stall_prod", longint'($signed(prod)) == 64'sd25, longint'($signed(prod)), 25);
                    @(negedge clk);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset in the middle of a frame with samples in flight
        send(3, 0, 1'b0, 1'b1, 64'sd9);
        send(3, 0, 1'b0, 1'b1, 64'sd9);
        idle();
        #1;
        reset = 1'b1;
        #1;
        check("arst_out_valid", out_valid == 1'b0, longint'(out_valid), 0);
        check("arst_prod", prod == '0, longint'(prod), 0);
        check("arst_acc_valid", acc_valid == 1'b0, longint'(acc_valid), 0);
        check("arst_acc_out", acc_out == '0, longint'(acc_out), 0);
        check("arst_acc_ovf", acc_ovf == 1'b0, longint'(acc_ovf), 0);
        model_reset();
        @(posedge clk);
        #1;
        check("arst_in_ready", in_ready == 1'b1, longint'(in_ready), 1);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) send(1, 0, 1'b0, 1'b1, 64'sd1);
        idle();
        drain();

        // Saturating frame, then a frame of zeros clears the flag
        for (int i = 0; i < 4; i++) send(-32768, 0, 1'b0, 1'b1, 64'sd1073741824);
        for (int i = 0; i < 4; i++) send(0, 5, 1'b0, 1'b1, 64'sd0);
        idle();
        drain();

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
